// File: rtl/approx_mac_pkg.sv
// Shared widths and arithmetic helpers for the approximate MAC datapath.
// approx_prod supports operands up to 16 bits; sat_add supports widths up to 32 bits.
package approx_mac_pkg;

  localparam int DEF_A_W         = 4;
  localparam int DEF_B_W         = 4;
  localparam int DEF_ACC_W       = 16;
  localparam int DEF_APPROX_COLS = 2;
  localparam int DEF_LEN_MAX     = 16;
  localparam int DEF_ERR_W       = 16;

  // Sum of partial products in columns >= cols; carries out of dropped columns are lost.
  function automatic logic [31:0] approx_prod(input logic [15:0] a, input logic [15:0] b,
                                              input int cols);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        if (((i + j) >= cols) && a[i] && b[j]) begin
          acc = acc + (32'd1 << (i + j));
        end
      end
    end
    return acc;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] x, input logic [31:0] y,
                                          input int w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, x} + {1'b0, y};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/approx_mac_seq_if.sv
// Operand stream in, per-packet result out; master drives operands and out_ready.
// Slave is the MAC side.
interface approx_mac_seq_if
  import approx_mac_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int ERR_W = DEF_ERR_W
);
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   in_a;
  logic [B_W-1:0]   in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_sat;
  logic             out_lenov;
  logic [ERR_W-1:0] out_err;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_sat, out_lenov, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_sat, out_lenov, out_err
  );
endinterface

// File: rtl/approx_mac_seq_mul_trunc.sv
// Combinational truncated partial-product multiplier; zero latency, no flow control.
// APPROX_COLS low product columns are never formed.
module approx_mul_trunc
  import approx_mac_pkg::*;
#(
  parameter int A_W         = DEF_A_W,
  parameter int B_W         = DEF_B_W,
  parameter int APPROX_COLS = DEF_APPROX_COLS
) (
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic [A_W+B_W-1:0] prod
);
  localparam int P_W = A_W + B_W;

  always_comb prod = P_W'(approx_prod(16'(a), 16'(b), APPROX_COLS));
endmodule

// File: rtl/approx_mac_seq.sv
// Streaming approximate MAC: beat -> S1 product -> S2 saturating accumulate -> 1-entry result buffer;
// last beat to out_valid 2 edges. Only a packet-end beat stalls on a full buffer. Option APPROX_MAC_ERRSTAT_EN.
module approx_mac_seq
  import approx_mac_pkg::*;
#(
  parameter int A_W         = DEF_A_W,
  parameter int B_W         = DEF_B_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int APPROX_COLS = DEF_APPROX_COLS,
  parameter int LEN_MAX     = DEF_LEN_MAX,
  parameter int ERR_W       = DEF_ERR_W
) (
  input logic             clk,
  input logic             rst,
  approx_mac_seq_if.slave bus
);
  localparam int          P_W     = A_W + B_W;
  localparam int          CNT_W   = $clog2(LEN_MAX + 1);
  localparam logic [32:0] ACC_MAX = (33'd1 << ACC_W) - 33'd1;

  logic [P_W-1:0]   mul_prod;
  logic             s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic [P_W-1:0]   s1_prod_q, s1_prod_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic             sat_q, sat_d, sat_nxt;
  logic             out_vld_q, out_vld_d, out_sat_q, out_sat_d, out_lenov_q, out_lenov_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic             len_hit, pkt_end, stall, fire;

  approx_mul_trunc #(.A_W(A_W), .B_W(B_W), .APPROX_COLS(APPROX_COLS)) u_mul (
    .a    (bus.in_a),
    .b    (bus.in_b),
    .prod (mul_prod)
  );

  always_comb begin
    acc_nxt = ACC_W'(sat_add(32'(acc_q), 32'(s1_prod_q), ACC_W));
    sat_nxt = sat_q | ((33'(acc_q) + 33'(s1_prod_q)) > ACC_MAX);
    cnt_nxt = cnt_q + CNT_W'(1);
    len_hit = (cnt_nxt == CNT_W'(LEN_MAX));
    pkt_end = s1_last_q | len_hit;
    stall   = s1_vld_q & pkt_end & out_vld_q & ~bus.out_ready;
    fire    = s1_vld_q & ~stall;
  end

  assign bus.in_ready = ~stall;

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_last_d = s1_last_q;
    s1_prod_d = s1_prod_q;
    if (!stall) begin
      s1_vld_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_last_d = bus.in_last;
        s1_prod_d = mul_prod;
      end
    end

    acc_d = acc_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (fire) begin
      acc_d = pkt_end ? '0 : acc_nxt;
      cnt_d = pkt_end ? '0 : cnt_nxt;
      sat_d = pkt_end ? 1'b0 : sat_nxt;
    end

    // A packet end landing on the same edge as a result accept refills the buffer.
    out_vld_d   = out_vld_q & ~bus.out_ready;
    out_acc_d   = out_acc_q;
    out_sat_d   = out_sat_q;
    out_lenov_d = out_lenov_q;
    if (fire && pkt_end) begin
      out_vld_d   = 1'b1;
      out_acc_d   = acc_nxt;
      out_sat_d   = sat_nxt;
      out_lenov_d = len_hit & ~s1_last_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_prod_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_vld_q   <= 1'b0;
      out_acc_q   <= '0;
      out_sat_q   <= 1'b0;
      out_lenov_q <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_last_q   <= s1_last_d;
      s1_prod_q   <= s1_prod_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_vld_q   <= out_vld_d;
      out_acc_q   <= out_acc_d;
      out_sat_q   <= out_sat_d;
      out_lenov_q <= out_lenov_d;
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_lenov = out_lenov_q;

`ifdef APPROX_MAC_ERRSTAT_EN
  logic [P_W-1:0]   s1_err_q, s1_err_d;
  logic [ERR_W-1:0] err_q, err_d, err_nxt, out_err_q, out_err_d;

  always_comb begin
    s1_err_d = s1_err_q;
    if (!stall && bus.in_valid) begin
      s1_err_d = P_W'(bus.in_a) * P_W'(bus.in_b) - mul_prod;
    end
    err_nxt   = ERR_W'(sat_add(32'(err_q), 32'(s1_err_q), ERR_W));
    err_d     = err_q;
    out_err_d = out_err_q;
    if (fire) begin
      err_d = pkt_end ? '0 : err_nxt;
    end
    if (fire && pkt_end) begin
      out_err_d = err_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_err_q  <= '0;
      err_q     <= '0;
      out_err_q <= '0;
    end else begin
      s1_err_q  <= s1_err_d;
      err_q     <= err_d;
      out_err_q <= out_err_d;
    end
  end

  assign bus.out_err = out_err_q;
`else
  assign bus.out_err = '0;
`endif
endmodule

// File: tb/tb_approx_mac_seq.sv
// Bench for approx_mac_seq: two instances (default config; exact/8-bit/LEN_MAX=4),
// packet-level reference model plus literal expectations.
module tb_approx_mac_seq;
  import approx_mac_pkg::*;

`ifdef APPROX_MAC_ERRSTAT_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  typedef struct {
    longint acc;
    longint sat;
    longint lenov;
    longint err;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  approx_mac_seq_if #(.A_W(4), .B_W(4), .ACC_W(16), .ERR_W(16)) ifa ();
  approx_mac_seq_if #(.A_W(4), .B_W(4), .ACC_W(8),  .ERR_W(16)) ifb ();

  approx_mac_seq #(.A_W(4), .B_W(4), .ACC_W(16), .APPROX_COLS(2), .LEN_MAX(16), .ERR_W(16))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  approx_mac_seq #(.A_W(4), .B_W(4), .ACC_W(8), .APPROX_COLS(0), .LEN_MAX(4), .ERR_W(16))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  int n_cmp = 0;
  int n_bad = 0;

  res_t exp0[$], exp1[$], got0[$], got1[$];
  longint m_acc[2], m_err[2];
  int     m_cnt[2];
  bit     m_sat[2];

  function automatic void chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++) begin
      m_acc[d] = 0; m_err[d] = 0; m_cnt[d] = 0; m_sat[d] = 1'b0;
    end
    exp0.delete();
    exp1.delete();
  endfunction

  // Packet-level reference: whole-beat approximate products summed and clamped per packet.
  function automatic void model_beat(input int d, input logic [3:0] a, input logic [3:0] b,
                                     input logic last);
    int     cols    = (d == 0) ? 2 : 0;
    int     accw    = (d == 0) ? 16 : 8;
    int     lenmax  = (d == 0) ? 16 : 4;
    longint mx      = (longint'(1) << accw) - 1;
    longint p       = longint'(approx_prod(16'(a), 16'(b), cols));
    longint e       = longint'(a) * longint'(b) - p;
    res_t   r;
    m_cnt[d]++;
    m_acc[d] = m_acc[d] + p;
    if (m_acc[d] > mx) begin
      m_acc[d] = mx;
      m_sat[d] = 1'b1;
    end
    if (ERR_ON != 0) m_err[d] = (m_err[d] + e > 65535) ? 65535 : m_err[d] + e;
    if (last || m_cnt[d] == lenmax) begin
      r.acc = m_acc[d]; r.sat = m_sat[d]; r.err = m_err[d];
      r.lenov = (m_cnt[d] == lenmax && !last) ? 1 : 0;
      if (d == 0) exp0.push_back(r); else exp1.push_back(r);
      m_acc[d] = 0; m_err[d] = 0; m_cnt[d] = 0; m_sat[d] = 1'b0;
    end
  endfunction

  function automatic void take(input int d, input res_t g);
    res_t e;
    bit   have;
    if (d == 0) got0.push_back(g); else got1.push_back(g);
    have = (d == 0) ? (exp0.size() != 0) : (exp1.size() != 0);
    chk($sformatf("dut%0d_result_expected", d), have, 1);
    if (have) begin
      e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
      chk($sformatf("dut%0d_acc", d),   g.acc,   e.acc);
      chk($sformatf("dut%0d_sat", d),   g.sat,   e.sat);
      chk($sformatf("dut%0d_lenov", d), g.lenov, e.lenov);
      chk($sformatf("dut%0d_err", d),   g.err,   e.err);
    end
  endfunction

  always @(negedge clk) begin
    res_t g;
    if (rst) begin
      model_clear();
    end else begin
      if (ifa.out_valid && ifa.out_ready) begin
        g.acc = ifa.out_acc; g.sat = ifa.out_sat; g.lenov = ifa.out_lenov; g.err = ifa.out_err;
        take(0, g);
      end
      if (ifb.out_valid && ifb.out_ready) begin
        g.acc = ifb.out_acc; g.sat = ifb.out_sat; g.lenov = ifb.out_lenov; g.err = ifb.out_err;
        take(1, g);
      end
      if (ifa.in_valid && ifa.in_ready) model_beat(0, ifa.in_a, ifa.in_b, ifa.in_last);
      if (ifb.in_valid && ifb.in_ready) model_beat(1, ifb.in_a, ifb.in_b, ifb.in_last);
    end
  end

  task automatic drive(input int d, input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic l);
    if (d == 0) begin
      ifa.in_valid = v; ifa.in_a = a; ifa.in_b = b; ifa.in_last = l;
    end else begin
      ifb.in_valid = v; ifb.in_a = a; ifb.in_b = b; ifb.in_last = l;
    end
  endtask

  task automatic beat(input int d, input int a, input int b, input logic l);
    bit ok = 1'b0;
    drive(d, 1'b1, 4'(a), 4'(b), l);
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = (d == 0) ? ifa.in_ready : ifb.in_ready;
    end
    chk("beat_accepted", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic wait_res(input int d, input int n);
    bit ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge clk); #2;
      ok = ((d == 0) ? got0.size() : got1.size()) >= n;
    end
    chk("results_arrived", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    idle(0); idle(1);
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_a", ifa.in_ready, 1);
    chk("rst_in_ready_b", ifb.in_ready, 1);
    chk("rst_out_valid_a", ifa.out_valid, 0);
    chk("rst_out_acc_a", ifa.out_acc, 0);
    chk("rst_out_err_a", ifa.out_err, 0);
    chk("rst_out_sat_b", ifb.out_sat, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready_a", ifa.in_ready, 1);

    // Single beat 15x15, two low columns dropped: 225 - 5 = 220.
    beat(0, 15, 15, 1'b1);
    idle(0);
    chk("t1_not_yet_valid", ifa.out_valid, 0);
    @(posedge clk); #1;
    chk("t1_valid", ifa.out_valid, 1);
    chk("t1_acc", ifa.out_acc, 220);
    chk("t1_err", ifa.out_err, (ERR_ON != 0) ? 5 : 0);

    // Exact product, three-beat dot product 15+14+1.
    n = got1.size();
    beat(1, 3, 5, 1'b0); beat(1, 7, 2, 1'b0); beat(1, 1, 1, 1'b1);
    idle(1);
    wait_res(1, n + 1);
    if (got1.size() > n) begin
      chk("t2_acc", got1[n].acc, 30);
      chk("t2_sat", got1[n].sat, 0);
      chk("t2_err", got1[n].err, 0);
    end

    // 8-bit accumulator saturates on 450; next single-beat packet starts clean.
    n = got1.size();
    beat(1, 15, 15, 1'b0); beat(1, 15, 15, 1'b1); beat(1, 1, 1, 1'b1);
    idle(1);
    wait_res(1, n + 2);
    if (got1.size() > n + 1) begin
      chk("t3_acc0", got1[n].acc, 255);
      chk("t3_sat0", got1[n].sat, 1);
      chk("t3_acc1", got1[n+1].acc, 1);
      chk("t3_sat1", got1[n+1].sat, 0);
    end

    // LEN_MAX=4 forces a split of a six-beat packet.
    n = got1.size();
    for (int i = 0; i < 6; i++) beat(1, 1, 1, (i == 5));
    idle(1);
    wait_res(1, n + 2);
    if (got1.size() > n + 1) begin
      chk("t4_acc0", got1[n].acc, 4);
      chk("t4_lenov0", got1[n].lenov, 1);
      chk("t4_acc1", got1[n+1].acc, 2);
      chk("t4_lenov1", got1[n+1].lenov, 0);
    end

    // Backpressure: result (5,6)=28 held, second packet (3,3)=4 stalls in S1.
    n = got0.size();
    ifa.out_ready = 1'b0;
    beat(0, 5, 6, 1'b1);
    beat(0, 3, 3, 1'b1);
    idle(0);
    chk("t5_in_ready_low", ifa.in_ready, 0);
    chk("t5_held_acc", ifa.out_acc, 28);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_still_stalled", ifa.in_ready, 0);
    chk("t5_still_held", ifa.out_acc, 28);
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_second_valid", ifa.out_valid, 1);
    chk("t5_second_acc", ifa.out_acc, 4);
    chk("t5_in_ready_back", ifa.in_ready, 1);
    @(posedge clk); #1;
    chk("t5_drained", ifa.out_valid, 0);
    wait_res(0, n + 2);
    chk("t5_count", got0.size(), n + 2);
    if (got0.size() > n + 1) begin
      chk("t5_res1", got0[n].acc, 28);
      chk("t5_res2", got0[n+1].acc, 4);
    end

    // Reset mid-packet discards the partial sum.
    for (int i = 0; i < 3; i++) beat(0, 3, 3, 1'b0);
    idle(0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_no_output", ifa.out_valid, 0);
    n = got0.size();
    beat(0, 2, 2, 1'b1);
    idle(0);
    wait_res(0, n + 1);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_count", got0.size(), n + 1);
    if (got0.size() > n) chk("t6_acc", got0[n].acc, 4);

    chk("end_pending_a", exp0.size(), 0);
    chk("end_pending_b", exp1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/approx_mac_seq.md
# approx_mac_seq

Streaming approximate multiply-accumulate unit: a parametrised, sequential successor to the single-shot approximate MAC partitions. Each beat carries an unsigned operand pair. The block forms a truncated partial-product (approximate) product, accumulates products per packet with saturation, and emits one dot-product result per packet through a one-entry output buffer with valid/ready handshakes. It sits between the operand streamer and the result collector in the approximate-datapath evaluation flow.

## Interface
Parameters:
- A_W, 4, operand A width (unsigned)
- B_W, 4, operand B width (unsigned)
- ACC_W, 16, accumulator/result width; must be ≥ A_W+B_W
- APPROX_COLS, 2, number of low product columns whose partial products are dropped; 0 gives an exact product
- LEN_MAX, 16, maximum beats per packet
- ERR_W, 16, error-sum width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat
- in_a  in  A_W  operand A
- in_b  in  B_W  operand B
- in_last  in  1  final beat of packet
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_acc  out  ACC_W  packet dot-product (approximate, saturated)
- out_sat  out  1  saturation occurred in this packet
- out_lenov  out  1  packet was force-terminated at LEN_MAX
- out_err  out  ERR_W  accumulated (exact − approx) error for the packet; tied 0 when the feature is compiled out

## Operation
- Approx product = Σ a[i]·b[j]·2^(i+j) over all i,j with i+j ≥ APPROX_COLS. Carries from dropped columns are lost; this is not a mask of the exact product.
- Stage 1 (S1): on handshake (in_valid && in_ready), register approx product, last flag and, if enabled, exact−approx.
- Stage 2 (S2): when S1 is valid and not stalled, acc_next = acc + prod.
  - If acc_next exceeds 2^ACC_W−1, clamp it to all-ones and set the sticky sat flag.
  - Increment the beat counter.
- Packet end: S1 last, or the beat counter reaching LEN_MAX; the latter sets lenov.
  - At packet end, load out_acc/out_sat/out_lenov/out_err from the next values and set out_valid.
  - Clear acc, counter, sat, lenov and err to 0 for the next packet.
- Output buffer: one entry. out_valid falls on the out_valid && out_ready edge unless a new packet end loads it on the same edge, in which case it stays 1 with new data.
- Stall = S1 valid && S1 packet end && out_valid && !out_ready.
  - While stalled, S1 and S2 hold their state.
  - in_ready = !stall (combinational).
- Non-end beats are never stalled by the output buffer.
- Error accumulation saturates at 2^ERR_W−1.

## Timing
- Reset values: out_valid=0, out_acc=0, out_sat=0, out_lenov=0, out_err=0, S1 valid=0, acc=0, counter=0. in_ready=1 while rst is high and after release.
- Latency: a last beat accepted at edge t gives out_valid=1 after edge t+1.
- Throughput: 1 beat/cycle, including back-to-back single-beat packets while out_ready=1.
- A result-accept and a new packet end on the same edge do not stall.
- Reset mid-packet: partial accumulation and any held result are discarded, with no output.
- in_a/in_b are ignored when in_valid=0.

## Configuration
- APPROX_MAC_ERRSTAT_EN defined:
  - Exact product is computed alongside the approximate one in S1.
  - The difference is accumulated per packet and presented on out_err.
- Not defined:
  - No exact multiplier or error registers are built.
  - out_err is constant 0.
  - All other behaviour is identical.

## Structure
- Package approx_mac_pkg holds:
  - default width constants;
  - function approx_prod(a, b, cols), shared by RTL and bench reference model;
  - saturating-add helper.
- Sub-module approx_mul_trunc: combinational truncated partial-product multiplier, parameters A_W, B_W, APPROX_COLS. S1 instantiates it.

## Test plan
- Single beat, A_W=B_W=4, APPROX_COLS=2, a=15, b=15, last=1:
  - out_acc=220 two edges after the handshake;
  - out_err=5 (exact 225) with the macro defined, 0 without.
- APPROX_COLS=0, packet (3,5),(7,2),(1,1) with last on the third beat: out_acc=30, out_err=0, out_sat=0.
- ACC_W=8, APPROX_COLS=0, two beats (15,15) and (15,15): out_acc=255, out_sat=1. The next packet (1,1) gives out_acc=1, out_sat=0.
- LEN_MAX=4, six beats (1,1) with last on the sixth:
  - first result out_acc=4, out_lenov=1;
  - second result out_acc=2, out_lenov=0.
- out_ready=0 with a result pending while a second single-beat packet is sent: in_ready falls while that last beat sits in S1. Raising out_ready gives result 1 on that edge and result 2 on the next edge, with no beat lost or duplicated.
- Assert rst mid-packet after 3 beats, then send (2,2) with last: out_acc equals the approx value of 2×2 only, and no result is emitted for the aborted packet.
